tt_vec_beat_serializer: RTL and testbench

- Upstream neighbour of the VPU skid buffer.
- Accepts one wide vector payload per rts/rtr handshake and emits it as 1..NUM_BEATS narrow beats on an rts/rtr output, lowest beat first.
- Output feeds the skid buffer directly. The skid buffer's registered o_rtr breaks this block's combinational i_rtr->o_rtr path.

---
 rtl/tt_vpu_pkg.sv | 14 +
 rtl/tt_vec_beat_mux.sv | 28 ++
 rtl/tt_vec_beat_serializer.sv | 108 ++++++++++
 tb/tb_tt_vec_beat_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_vpu_pkg.sv
// Shared VPU definitions: serializer state encoding and count-width helper.
package tt_vpu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   // Index width for n beats, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tt_vec_beat_mux.sv
// Combinational beat selector: picks beat i_sel out of a flat multi-beat payload.
module tt_vec_beat_mux #(
   parameter int BEAT_WIDTH = 32,
   parameter int NUM_BEATS  = 4,
   parameter int SEL_WIDTH  = 2
) (
   input  logic [NUM_BEATS*BEAT_WIDTH-1:0] i_pld,
   input  logic [SEL_WIDTH-1:0]            i_sel,
   output logic [BEAT_WIDTH-1:0]           o_beat
);

   logic [BEAT_WIDTH-1:0] w_beats [NUM_BEATS];

   for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_split
      assign w_beats[gi] = i_pld[gi*BEAT_WIDTH +: BEAT_WIDTH];
   end

   // Compare-and-select keeps a selector wider than the beat count from indexing past the array.
   always_comb begin
      o_beat = '0;
      for (int k = 0; k < NUM_BEATS; k++) begin
         if (i_sel == SEL_WIDTH'(k)) begin
            o_beat = w_beats[k];
         end
      end
   end

endmodule

// File: rtl/tt_vec_beat_serializer.sv
// Splits one wide payload per rts/rtr handshake into 1..NUM_BEATS narrow beats, lowest first,
// with zero-bubble reload on the final beat.
module tt_vec_beat_serializer
   import tt_vpu_pkg::*;
#(
   parameter int BEAT_WIDTH = 32,
   parameter int NUM_BEATS  = 4,
   parameter int CNT_WIDTH  = cnt_width(NUM_BEATS)
) (
   input  logic                            i_clk,
   input  logic                            i_reset_n,
   input  logic                            i_rts,
   output logic                            o_rtr,
   input  logic [NUM_BEATS*BEAT_WIDTH-1:0] i_pld,
   input  logic [CNT_WIDTH-1:0]            i_nbeats_m1,
   output logic                            o_rts,
   input  logic                            i_rtr,
   output logic [BEAT_WIDTH-1:0]           o_pld,
   output logic [CNT_WIDTH-1:0]            o_beat_idx,
   output logic                            o_last,
   output logic                            o_busy
);

   localparam logic [CNT_WIDTH-1:0] LP_MAX_IDX = CNT_WIDTH'(NUM_BEATS - 1);

   ser_state_e                      r_state;
   ser_state_e                      w_state_next;
   logic [NUM_BEATS*BEAT_WIDTH-1:0] r_hold_pld;
   logic [CNT_WIDTH-1:0]            r_hold_n;
   logic [CNT_WIDTH-1:0]            r_beat_cnt;
   logic [CNT_WIDTH-1:0]            w_beat_cnt_next;
   logic [CNT_WIDTH-1:0]            w_nbeats_clamp;
   logic                            w_accept;
   logic                            w_beat_hs;

   assign o_rts      = (r_state == SEND);
   assign o_busy     = (r_state == SEND);
   assign o_beat_idx = r_beat_cnt;
   assign o_last     = (r_state == SEND) && (r_beat_cnt == r_hold_n);
   assign w_beat_hs  = o_rts && i_rtr;
   // Ready while the final beat leaves, so the next payload lands without a bubble.
   assign o_rtr      = (r_state == IDLE) || (w_beat_hs && o_last);
   assign w_accept   = i_rts && o_rtr;

   assign w_nbeats_clamp = (i_nbeats_m1 > LP_MAX_IDX) ? LP_MAX_IDX : i_nbeats_m1;

   always_comb begin
      w_state_next    = r_state;
      w_beat_cnt_next = r_beat_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next    = SEND;
               w_beat_cnt_next = '0;
            end
         end
         SEND: begin
            if (w_beat_hs) begin
               if (!o_last) begin
                  w_beat_cnt_next = r_beat_cnt + CNT_WIDTH'(1);
               end else if (w_accept) begin
                  w_state_next    = SEND;
                  w_beat_cnt_next = '0;
               end else begin
                  w_state_next    = IDLE;
                  w_beat_cnt_next = '0;
               end
            end
         end
         default: begin
            w_state_next    = IDLE;
            w_beat_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
         r_hold_n   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_beat_cnt <= w_beat_cnt_next;
         if (w_accept) begin
            r_hold_n <= w_nbeats_clamp;
         end
      end
   end

   // Payload storage is qualified by state everywhere it is observed, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_hold_pld <= i_pld;
      end
   end

   tt_vec_beat_mux #(
      .BEAT_WIDTH (BEAT_WIDTH),
      .NUM_BEATS  (NUM_BEATS),
      .SEL_WIDTH  (CNT_WIDTH)
   ) u_beat_mux (
      .i_pld  (r_hold_pld),
      .i_sel  (r_beat_cnt),
      .o_beat (o_pld)
   );

endmodule

// File: tb/tb_tt_vec_beat_serializer.sv
// Directed table plus reset and random-backpressure scoreboard checks for tt_vec_beat_serializer.
module tb_tt_vec_beat_serializer;

   localparam int BW   = 32;
   localparam int NB   = 4;
   localparam int CW   = 3;
   localparam int NPAY = 1000;

   logic              i_clk = 1'b0;
   logic              i_reset_n;
   logic              i_rts;
   logic              o_rtr;
   logic [NB*BW-1:0]  i_pld;
   logic [CW-1:0]     i_nbeats_m1;
   logic              o_rts;
   logic              i_rtr;
   logic [BW-1:0]     o_pld;
   logic [CW-1:0]     o_beat_idx;
   logic              o_last;
   logic              o_busy;

   int n_vec  = 0;
   int n_miss = 0;

   tt_vec_beat_serializer #(
      .BEAT_WIDTH (BW),
      .NUM_BEATS  (NB),
      .CNT_WIDTH  (CW)
   ) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_rts       (i_rts),
      .o_rtr       (o_rtr),
      .i_pld       (i_pld),
      .i_nbeats_m1 (i_nbeats_m1),
      .o_rts       (o_rts),
      .i_rtr       (i_rtr),
      .o_pld       (o_pld),
      .o_beat_idx  (o_beat_idx),
      .o_last      (o_last),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic          rts;
      logic [NB*BW-1:0] pld;
      logic [CW-1:0] nbm1;
      logic          rtr;
      logic          e_rts;
      logic          e_rtr;
      logic [BW-1:0] e_pld;
      logic          chk_pld;
      logic [CW-1:0] e_idx;
      logic          e_last;
   } vec_t;

   typedef struct {
      logic [BW-1:0] pld;
      logic [CW-1:0] idx;
      logic          last;
   } beat_t;

   vec_t  tbl[$];
   beat_t exp_q[$];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic vec_t mk(input logic rts, input logic [NB*BW-1:0] pld, input logic [CW-1:0] nbm1,
                               input logic rtr, input logic e_rts, input logic e_rtr,
                               input logic [BW-1:0] e_pld, input logic chk_pld,
                               input logic [CW-1:0] e_idx, input logic e_last);
      vec_t v;
      v.rts = rts; v.pld = pld; v.nbm1 = nbm1; v.rtr = rtr;
      v.e_rts = e_rts; v.e_rtr = e_rtr; v.e_pld = e_pld; v.chk_pld = chk_pld;
      v.e_idx = e_idx; v.e_last = e_last;
      return v;
   endfunction

   function automatic vec_t idle(input logic rts, input logic [NB*BW-1:0] pld, input logic [CW-1:0] nbm1);
      return mk(rts, pld, nbm1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 3'd0, 1'b0);
   endfunction

   function automatic vec_t bt(input logic rtr, input logic e_rtr, input logic [BW-1:0] e_pld,
                               input logic [CW-1:0] e_idx, input logic e_last);
      return mk(1'b0, '0, 3'd0, rtr, 1'b1, e_rtr, e_pld, 1'b1, e_idx, e_last);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB*BW-1:0] p4, p0, p1, pq, pr, pz;
      int               sent;
      int               cyc;
      bit               have;
      logic [NB*BW-1:0] cur_p;
      logic [CW-1:0]    cur_n;
      bit               prev_stall;
      logic [BW-1:0]    prev_pld;
      logic [CW-1:0]    prev_idx;
      logic             prev_last;
      beat_t            b;

      p4 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      p0 = {32'h0000_00EE, 32'h0000_00EF, 32'h0000_0011, 32'h0000_0010};
      p1 = {32'h0000_00EE, 32'h0000_0022, 32'h0000_0021, 32'h0000_0020};
      pq = {32'h0000_0054, 32'h0000_0053, 32'h0000_0052, 32'h0000_0051};
      pr = {32'h0000_0064, 32'h0000_0063, 32'h0000_0062, 32'h0000_0061};
      pz = {NB*BW{1'b1}};

      // Basic 4-beat payload
      tbl.push_back(idle(1'b1, p4, 3'd3));
      tbl.push_back(bt(1'b1, 1'b0, 32'hAAAA_AAAA, 3'd0, 1'b0));
      tbl.push_back(bt(1'b1, 1'b0, 32'hBBBB_BBBB, 3'd1, 1'b0));
      tbl.push_back(bt(1'b1, 1'b0, 32'hCCCC_CCCC, 3'd2, 1'b0));
      tbl.push_back(bt(1'b1, 1'b1, 32'hDDDD_DDDD, 3'd3, 1'b1));
      tbl.push_back(idle(1'b0, '0, 3'd0));
      // Back-to-back 2-beat then 3-beat
      tbl.push_back(idle(1'b1, p0, 3'd1));
      tbl.push_back(mk(1'b1, p1, 3'd2, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 3'd0, 1'b0));
      tbl.push_back(mk(1'b1, p1, 3'd2, 1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 3'd1, 1'b1));
      tbl.push_back(bt(1'b1, 1'b0, 32'h20, 3'd0, 1'b0));
      tbl.push_back(bt(1'b1, 1'b0, 32'h21, 3'd1, 1'b0));
      tbl.push_back(bt(1'b1, 1'b1, 32'h22, 3'd2, 1'b1));
      tbl.push_back(idle(1'b0, '0, 3'd0));
      // Backpressure on beat 1, plus an upstream offer withdrawn while not ready
      tbl.push_back(idle(1'b1, p4, 3'd3));
      tbl.push_back(bt(1'b1, 1'b0, 32'hAAAA_AAAA, 3'd0, 1'b0));
      tbl.push_back(mk(1'b1, pz, 3'd0, 1'b0, 1'b1, 1'b0, 32'hBBBB_BBBB, 1'b1, 3'd1, 1'b0));
      tbl.push_back(bt(1'b0, 1'b0, 32'hBBBB_BBBB, 3'd1, 1'b0));
      tbl.push_back(bt(1'b0, 1'b0, 32'hBBBB_BBBB, 3'd1, 1'b0));
      tbl.push_back(bt(1'b1, 1'b0, 32'hBBBB_BBBB, 3'd1, 1'b0));
      tbl.push_back(bt(1'b1, 1'b0, 32'hCCCC_CCCC, 3'd2, 1'b0));
      tbl.push_back(bt(1'b0, 1'b0, 32'hDDDD_DDDD, 3'd3, 1'b1));
      tbl.push_back(bt(1'b1, 1'b1, 32'hDDDD_DDDD, 3'd3, 1'b1));
      tbl.push_back(idle(1'b0, '0, 3'd0));
      // Single-beat payloads, reload on the handshaking beat
      tbl.push_back(idle(1'b1, pq, 3'd0));
      tbl.push_back(mk(1'b1, pr, 3'd0, 1'b1, 1'b1, 1'b1, 32'h51, 1'b1, 3'd0, 1'b1));
      tbl.push_back(bt(1'b1, 1'b1, 32'h61, 3'd0, 1'b1));
      tbl.push_back(idle(1'b0, '0, 3'd0));
      // Out-of-range count clamps to 4 beats
      tbl.push_back(idle(1'b1, p4, 3'd7));
      tbl.push_back(bt(1'b1, 1'b0, 32'hAAAA_AAAA, 3'd0, 1'b0));
      tbl.push_back(bt(1'b1, 1'b0, 32'hBBBB_BBBB, 3'd1, 1'b0));
      tbl.push_back(bt(1'b1, 1'b0, 32'hCCCC_CCCC, 3'd2, 1'b0));
      tbl.push_back(bt(1'b1, 1'b1, 32'hDDDD_DDDD, 3'd3, 1'b1));
      tbl.push_back(idle(1'b0, '0, 3'd0));

      // Reset state
      i_reset_n = 1'b0; i_rts = 1'b0; i_pld = '0; i_nbeats_m1 = '0; i_rtr = 1'b0;
      #1;
      chk("reset o_rts", 32'(o_rts), 32'(1'b0));
      chk("reset o_busy", 32'(o_busy), 32'(1'b0));
      chk("reset o_beat_idx", 32'(o_beat_idx), 32'(3'd0));
      chk("reset o_last", 32'(o_last), 32'(1'b0));
      #21;
      i_reset_n = 1'b1;
      #1;
      chk("post-reset o_rtr", 32'(o_rtr), 32'(1'b1));

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge i_clk); #1;
         i_rts = tbl[i].rts; i_pld = tbl[i].pld; i_nbeats_m1 = tbl[i].nbm1; i_rtr = tbl[i].rtr;
         #3;
         chk($sformatf("row%0d o_rts", i), 32'(o_rts), 32'(tbl[i].e_rts));
         chk($sformatf("row%0d o_rtr", i), 32'(o_rtr), 32'(tbl[i].e_rtr));
         chk($sformatf("row%0d o_beat_idx", i), 32'(o_beat_idx), 32'(tbl[i].e_idx));
         chk($sformatf("row%0d o_last", i), 32'(o_last), 32'(tbl[i].e_last));
         chk($sformatf("row%0d o_busy", i), 32'(o_busy), 32'(tbl[i].e_rts));
         if (tbl[i].chk_pld) begin
            chk($sformatf("row%0d o_pld", i), o_pld, tbl[i].e_pld);
         end
      end

      // Asynchronous reset during beat 2 of 4
      @(posedge i_clk); #1;
      i_rts = 1'b1; i_pld = p4; i_nbeats_m1 = 3'd3; i_rtr = 1'b1;
      @(posedge i_clk); #1;
      i_rts = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      chk("mid-reset pre o_beat_idx", 32'(o_beat_idx), 32'(3'd2));
      chk("mid-reset pre o_rts", 32'(o_rts), 32'(1'b1));
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("mid-reset o_rts async", 32'(o_rts), 32'(1'b0));
      chk("mid-reset o_busy async", 32'(o_busy), 32'(1'b0));
      chk("mid-reset o_beat_idx", 32'(o_beat_idx), 32'(3'd0));
      @(posedge i_clk); #2;
      i_reset_n = 1'b1;
      #1;
      chk("mid-reset release o_rtr", 32'(o_rtr), 32'(1'b1));
      for (int i = 0; i < 6; i++) begin
         @(posedge i_clk); #4;
         chk($sformatf("post-reset stale beat cyc%0d", i), 32'(o_rts), 32'(1'b0));
      end

      // Random payloads, counts and backpressure against a beat scoreboard
      sent = 0; cyc = 0; have = 1'b0; prev_stall = 1'b0;
      cur_p = '0; cur_n = '0; prev_pld = '0; prev_idx = '0; prev_last = 1'b0;
      while ((sent < NPAY || exp_q.size() != 0) && cyc < 40000) begin
         @(posedge i_clk); #1;
         cyc++;
         if (!have && sent < NPAY && $urandom_range(0, 3) != 0) begin
            cur_p = {$urandom, $urandom, $urandom, $urandom};
            cur_n = 3'($urandom_range(0, 7));
            have  = 1'b1;
         end
         i_rts = have; i_pld = cur_p; i_nbeats_m1 = cur_n; i_rtr = 1'($urandom_range(0, 1));
         #3;
         if (prev_stall) begin
            chk("rand stall o_rts", 32'(o_rts), 32'(1'b1));
            chk("rand stall o_pld", o_pld, prev_pld);
            chk("rand stall o_beat_idx", 32'(o_beat_idx), 32'(prev_idx));
            chk("rand stall o_last", 32'(o_last), 32'(prev_last));
         end
         if (o_rts && i_rtr) begin
            if (exp_q.size() == 0) begin
               chk("rand unexpected beat", 32'(o_rts), 32'(1'b0));
            end else begin
               b = exp_q.pop_front();
               chk("rand o_pld", o_pld, b.pld);
               chk("rand o_beat_idx", 32'(o_beat_idx), 32'(b.idx));
               chk("rand o_last", 32'(o_last), 32'(b.last));
            end
         end
         if (i_rts && o_rtr) begin
            for (int k = 0; k < ((cur_n > 3'd3) ? 4 : int'(cur_n) + 1); k++) begin
               b.pld  = cur_p[k*BW +: BW];
               b.idx  = 3'(k);
               b.last = (k == ((cur_n > 3'd3) ? 3 : int'(cur_n)));
               exp_q.push_back(b);
            end
            have = 1'b0;
            sent++;
         end
         prev_stall = o_rts && !i_rtr;
         prev_pld   = o_pld;
         prev_idx   = o_beat_idx;
         prev_last  = o_last;
      end
      chk("rand payloads accepted", 32'(sent), 32'(NPAY));
      chk("rand beats outstanding", 32'(exp_q.size()), 32'(0));
      i_rts = 1'b0; i_rtr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge i_clk); #4;
         chk($sformatf("rand drained no extra beat cyc%0d", i), 32'(o_rts), 32'(1'b0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
